pc_fetch_unit: RTL

- Program-counter register and instruction-fetch sequencer. It sits directly downstream of the PC select mux and consumes its 32-bit result as the next sequential/branch PC.
- Holds the architectural PC and issues one instruction-memory request at a time with a valid/ready handshake. Presents the fetched instruction, tagged with its PC, to decode.
- A flush input from execute redirects the PC at any time. Misaligned targets raise a sticky fault.

---
 rtl/pc_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Holds the PC, requests imem over valid/ready, and hands the fetched word to decode.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_next,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] pc_out,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            fault_q, fault_d;

    logic            pc_wr;
    logic [XLEN-1:0] pc_wr_val;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;
        pc_wr         = 1'b0;
        pc_wr_val     = pc_q;

        case (state_q)
            S_FETCH: begin
                if (flush) begin
                    pc_wr     = 1'b1;
                    pc_wr_val = flush_pc;
                end
                // A flush racing the accept still lets the old request go; its response is dropped.
                if (req_valid_q && imem_req_ready) begin
                    state_d = S_WAIT;
                    if (flush) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                        if (flush) begin
                            pc_wr     = 1'b1;
                            pc_wr_val = flush_pc;
                        end
                    end else begin
                        instr_d       = imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (flush) begin
                    pc_wr     = 1'b1;
                    pc_wr_val = flush_pc;
                    drop_d    = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_wr         = 1'b1;
                    pc_wr_val     = flush_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end else if (instr_ready) begin
                    pc_wr         = 1'b1;
                    pc_wr_val     = pc_next;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            default: ;
        endcase

        // Misaligned targets are still recorded in the PC, then fetching stops for good.
        if (pc_wr) begin
            pc_d = pc_wr_val;
            if (pc_wr_val[1:0] != 2'b00) begin
                state_d       = S_FAULT;
                fault_d       = 1'b1;
                instr_valid_d = 1'b0;
                drop_d        = 1'b0;
            end
        end

        req_valid_d = (state_d == S_FETCH);
        req_addr_d  = (state_d == S_FETCH) ? pc_d : req_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign pc_out         = pc_q;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = fault_q;

endmodule
